fb_scan_arbiter: RTL
====================

# fb_scan_arbiter

Single-port framebuffer arbiter. It shares one synchronous-read RAM between display scan-out and a drawing client. Inside the active-video fetch window the display owns the port and reads pixels in raster order; outside it, the drawing client is granted single-cycle writes. It sits between the VGA timing counters (hcount/vcount), the framebuffer RAM and the pixel output stage.

## Interface
- H_ACT_START, 144, first active hcount
- H_ACT_END, 784, first hcount past active region (exclusive)
- V_ACT_START, 35, first active vcount
- V_ACT_END, 515, first vcount past active region (exclusive)
- FB_WORDS, 307200, framebuffer depth (640x480)
- ADDR_W, 19, RAM address width
- DATA_W, 8, pixel width
- clk  in  1  system/pixel clock; one clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hcount  in  10  horizontal counter from timing generator
- vcount  in  10  vertical counter from timing generator
- wr_req  in  1  drawing client write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  write accepted this cycle (combinational)
- wr_oob  out  1  one-cycle pulse: accepted write was out of range, dropped
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, 1-cycle latency after mem_addr
- pix_data  out  DATA_W  pixel to display, 0 when not valid
- pix_valid  out  1  pix_data is an active pixel
- scan_active  out  1  FSM in S_SCAN
- frame_start  out  1  one-cycle pulse at hcount==0 && vcount==0

## Operation
- Fetch lead is 3 cycles: decision (t), mem_addr register (t+1), RAM data (t+2), pix_data register (t+3).
- scan_win (combinational): vcount in [V_ACT_START, V_ACT_END) and hcount in [H_ACT_START-3, H_ACT_END-3).
- FSM states:
  - S_BLANK: reset state. Goes to S_SCAN when scan_win=1.
  - S_SCAN: goes to S_BLANK when scan_win=0.
  - scan_active is the registered state.
- Read counter rd_ptr (ADDR_W bits):
  - Cleared to 0 on reset.
  - Cleared to 0 on any cycle with hcount==0 && vcount==0; that clear wins over increment.
  - Increments by 1 on each scan_win cycle.
  - Linear raster order; no multiply.
- scan_win=1: next mem_addr=rd_ptr, mem_we=0. wr_gnt=0 regardless of wr_req.
- scan_win=0 and wr_req=1: wr_gnt=1.
  - wr_addr<FB_WORDS: next mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1.
  - wr_addr>=FB_WORDS: mem_we=0 and wr_oob pulses on the next cycle.
- scan_win=0 and wr_req=0: mem_we=0; mem_addr holds.
- Client holds wr_req/wr_addr/wr_data until it sees wr_gnt=1. One write per granted cycle; back-to-back grants are allowed.
- Valid pipeline: 3-stage shift of scan_win. pix_valid=stage 3. pix_data=mem_rdata registered when stage 2=1, else 0.

## Timing
- Reset values:
  - mem_addr=0, mem_we=0, mem_wdata=0
  - pix_data=0, pix_valid=0
  - scan_active=0, frame_start=0, wr_oob=0
  - rd_ptr=0, valid pipeline cleared, state S_BLANK
  - wr_gnt=0 while rst_n=0
- First pixel: scan_win rises at hcount=141. pix_valid rises at hcount=144 carrying address rd_ptr of that line start. It falls after hcount=783: exactly 640 valid cycles per active line.
- Writer latency: grant in cycle t, RAM write at t+1 edge. A write and a display read of the same address never share a cycle.
- Reset mid-frame: in-flight reads are discarded and pix_valid drops immediately. After release, rd_ptr restarts at 0, so the picture is misaligned until the next frame_start re-zeros it.
- wr_req arriving on the cycle scan_win rises: not granted; held until the window closes.
- Worst-case writer stall is 640 cycles per line during active lines.
- rd_ptr reaches 307200 after the last active line and holds there until the frame_start clear; it never wraps within a frame.

## Test plan
- Reset then free-run timing (800x525): pix_valid high exactly 640 cycles per line for 480 lines. First valid pix_data corresponds to address 0 at hcount=144, vcount=35. Last is address 307199.
- RAM preloaded with data=addr[7:0]: pix_data at hcount=144+k, line 36, equals (640+k)[7:0].
- wr_req held with wr_addr=100, wr_data=0xAB starting at hcount=140, vcount=35: wr_gnt=1 at 140, mem_we=1 with addr 100 at 141, no grant at 141..780, grant resumes at 781.
- Writer streaming at vcount=10 (blanking): wr_gnt=1 every cycle; mem_we follows 1 cycle later with matching addr/data.
- wr_addr=307200 granted in blanking: mem_we stays 0; wr_oob pulses 1 cycle after the grant.
- rst_n asserted at hcount=400, vcount=200 for 5 cycles: all outputs 0 at once. After release, pix_valid resumes next window; frame_start re-zeros rd_ptr, and frame 2 first pixel is address 0.

Source files
------------

// File: rtl/fb_scan_arbiter.sv
// -----------------------------------------------------------------------------
// fb_scan_arbiter
//
// Shares one synchronous-read framebuffer RAM port between display scan-out
// and a drawing client. While the fetch window is open (3 cycles ahead of the
// active video region) the display owns the port and reads pixels in linear
// raster order. Outside the window the drawing client gets single-cycle
// writes; writes addressed past the framebuffer are accepted but dropped and
// flagged on wr_oob.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   hcount, vcount        timing-generator counters
//   wr_req/addr/data      drawing client request (held until wr_gnt)
//   wr_gnt                combinational grant for the current cycle
//   wr_oob                pulse: previous grant was out of range
//   mem_addr/we/wdata     registered RAM port controls
//   mem_rdata             RAM read data, one cycle after mem_addr
//   pix_data, pix_valid   pixel to display (0 when not valid)
//   scan_active           FSM is in the scan state
//   frame_start           pulse one cycle after hcount==0 && vcount==0
// -----------------------------------------------------------------------------
module fb_scan_arbiter #(
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515,
    parameter int unsigned FB_WORDS    = 307200,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_oob,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              scan_active,
    output logic              frame_start
);

    // The fetch window opens three cycles early: address register, RAM
    // latency and pixel register each take one cycle.
    localparam int unsigned FETCH_LEAD = 3;

    localparam logic [9:0]        H_WIN_LO = 10'(H_ACT_START - FETCH_LEAD);
    localparam logic [9:0]        H_WIN_HI = 10'(H_ACT_END - FETCH_LEAD);
    localparam logic [9:0]        V_WIN_LO = 10'(V_ACT_START);
    localparam logic [9:0]        V_WIN_HI = 10'(V_ACT_END);
    localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_WORDS);

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_SCAN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                wr_oob_q, wr_oob_d;
    logic [2:0]          valid_q, valid_d;
    logic [DATA_W-1:0]   pix_data_q, pix_data_d;
    logic                frame_start_q, frame_start_d;

    logic                scan_win_s;
    logic                frame_clr_s;
    logic                wr_take_s;
    logic                wr_in_range_s;

    // Window decode, frame-origin detect and write acceptance.
    always_comb begin
        scan_win_s    = (vcount >= V_WIN_LO) && (vcount < V_WIN_HI) &&
                        (hcount >= H_WIN_LO) && (hcount < H_WIN_HI);
        frame_clr_s   = (hcount == 10'd0) && (vcount == 10'd0);
        wr_take_s     = !scan_win_s && wr_req;
        wr_in_range_s = (wr_addr < FB_LIMIT);
        // Grant is combinational but must read as 0 while held in reset.
        wr_gnt        = wr_take_s && rst_n;
    end

    // FSM next state: tracks the fetch window.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BLANK: begin
                if (scan_win_s) begin
                    state_d = S_SCAN;
                end else begin
                    state_d = S_BLANK;
                end
            end
            S_SCAN: begin
                if (!scan_win_s) begin
                    state_d = S_BLANK;
                end else begin
                    state_d = S_SCAN;
                end
            end
            default: begin
                state_d = S_BLANK;
            end
        endcase
    end

    // Port arbitration, read pointer and pixel pipeline next-state.
    always_comb begin
        mem_addr_d    = mem_addr_q;
        mem_we_d      = 1'b0;
        mem_wdata_d   = mem_wdata_q;
        wr_oob_d      = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        frame_start_d = frame_clr_s;
        valid_d       = {valid_q[1:0], scan_win_s};

        if (scan_win_s) begin
            mem_addr_d = rd_ptr_q;
        end else if (wr_take_s && wr_in_range_s) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
            mem_we_d    = 1'b1;
        end else if (wr_take_s) begin
            // Out-of-range write is consumed (granted) but never reaches RAM.
            wr_oob_d = 1'b1;
        end else begin
            mem_we_d = 1'b0;
        end

        // Frame-origin clear has priority; pointer never wraps inside a frame.
        if (frame_clr_s) begin
            rd_ptr_d = {ADDR_W{1'b0}};
        end else if (scan_win_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // valid_q[1] marks the cycle where mem_rdata belongs to a scan read.
        if (valid_q[1]) begin
            pix_data_d = mem_rdata;
        end else begin
            pix_data_d = {DATA_W{1'b0}};
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_BLANK;
            rd_ptr_q      <= {ADDR_W{1'b0}};
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= {DATA_W{1'b0}};
            wr_oob_q      <= 1'b0;
            valid_q       <= 3'b000;
            pix_data_q    <= {DATA_W{1'b0}};
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            wr_oob_q      <= wr_oob_d;
            valid_q       <= valid_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign wr_oob      = wr_oob_q;
    assign pix_data    = pix_data_q;
    assign pix_valid   = valid_q[2];
    assign scan_active = (state_q == S_SCAN);
    assign frame_start = frame_start_q;

endmodule
